// File: rtl/sp3_uplink_tx_pkg.sv
// Shared definitions for the SP3 uplink frame transmitter.
//   LANE_W    - width of one payload word / lane
//   N_PAYLOAD - payload lanes per frame
//   FRAME_W   - full frame width (header lane + payload lanes)
//   HDR_DATA / HDR_IDLE - frame type codes carried in header bits [17:16]
//   state_t   - assembly buffer occupancy state
//   chk_fold  - folds an 18-bit XOR accumulator into the 4-bit header checksum
package sp3_uplink_tx_pkg;

  localparam int unsigned LANE_W    = 18;
  localparam int unsigned N_PAYLOAD = 12;
  localparam int unsigned FRAME_W   = 234;

  localparam logic [1:0] HDR_DATA = 2'b10;
  localparam logic [1:0] HDR_IDLE = 2'b01;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FULL
  } state_t;

  function automatic logic [3:0] chk_fold(input logic [LANE_W-1:0] x);
    return x[3:0] ^ x[7:4] ^ x[11:8] ^ x[15:12] ^ {2'b00, x[17:16]};
  endfunction

endpackage

// File: rtl/sp3_uplink_frame_tx.sv
// SP3 uplink emulator: packs 18-bit words into 234-bit uplink user-data
// frames, one frame per frame_tick. Partial frames are flushed after
// FLUSH_TICKS ticks or when en drops; empty ticks emit idle frames.
//   S_AXI_ACLK         - clock
//   S_AXI_ARESETN      - asynchronous active-low reset
//   en                 - enable; low blocks input and forces flush/idle
//   frame_tick         - one-cycle frame-rate pulse
//   s_data/s_valid     - input word stream
//   s_ready            - word accepted on s_valid & s_ready
//   uplinkUserData     - current frame {header, lane 11 .. lane 0}
//   uplinkFrameValid_o - 1 for data frames, 0 for idle frames
//   data_frame_cnt     - data frames emitted (wraps)
module sp3_uplink_frame_tx
  import sp3_uplink_tx_pkg::*;
#(
  parameter int unsigned       FLUSH_TICKS = 4,
  parameter logic [LANE_W-1:0] IDLE_WORD   = 18'h2AAAA
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic               en,
  input  logic               frame_tick,
  input  logic [LANE_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [FRAME_W-1:0] uplinkUserData,
  output logic               uplinkFrameValid_o,
  output logic [31:0]        data_frame_cnt
);

  state_t                            state_q, state_d;
  logic [N_PAYLOAD-1:0][LANE_W-1:0]  lanes_q, lanes_d;
  logic [3:0]                        wcnt_q, wcnt_d;
  logic [3:0]                        wait_q, wait_d;
  logic [LANE_W-1:0]                 x_q, x_d;
  logic [7:0]                        seq_q, seq_d;
  logic [FRAME_W-1:0]                frame_d;
  logic                              fvalid_d;
  logic [31:0]                       dcnt_d;
  logic                              accept;
  logic                              flush;

  // Held low during reset so nothing is taken while the buffer is cleared.
  assign s_ready = S_AXI_ARESETN & en & (wcnt_q < 4'(N_PAYLOAD));
  assign accept  = s_valid & s_ready;

  assign flush = (state_q == FULL) ||
                 ((state_q == FILL) && ((wait_q == 4'(FLUSH_TICKS - 1)) || !en));

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    lanes_d  = lanes_q;
    wcnt_d   = wcnt_q;
    wait_d   = wait_q;
    x_d      = x_q;
    seq_d    = seq_q;
    frame_d  = uplinkUserData;
    fvalid_d = uplinkFrameValid_o;
    dcnt_d   = data_frame_cnt;

    if (frame_tick) begin
      if (flush) begin
        frame_d  = {HDR_DATA, seq_q, wcnt_q, chk_fold(x_q), lanes_q};
        fvalid_d = 1'b1;
        seq_d    = seq_q + 8'd1;
        dcnt_d   = data_frame_cnt + 32'd1;
        lanes_d  = '0;
        wcnt_d   = '0;
        wait_d   = '0;
        x_d      = '0;
      end else begin
        frame_d  = {HDR_IDLE, seq_q, 4'h0, 4'h0, {N_PAYLOAD{IDLE_WORD}}};
        fvalid_d = 1'b0;
        if (state_q == FILL) begin
          wait_d = wait_q + 4'd1;
        end
      end
    end

    // Acceptance works on the post-emit view, so a word taken on a flushing
    // tick lands as word 0 of the fresh assembly.
    if (accept) begin
      if (wcnt_d == 4'd0) begin
        wait_d = '0;
        x_d    = s_data;
      end else begin
        x_d = x_d ^ s_data;
      end
      for (int unsigned i = 0; i < N_PAYLOAD; i++) begin
        if (wcnt_d == 4'(i)) begin
          lanes_d[i] = s_data;
        end
      end
      wcnt_d = wcnt_d + 4'd1;
    end

    if (wcnt_d == 4'd0) begin
      state_d = EMPTY;
    end else if (wcnt_d == 4'(N_PAYLOAD)) begin
      state_d = FULL;
    end else begin
      state_d = FILL;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      lanes_q            <= '0;
      wcnt_q             <= '0;
      wait_q             <= '0;
      x_q                <= '0;
      seq_q              <= '0;
      uplinkUserData     <= '0;
      uplinkFrameValid_o <= 1'b0;
      data_frame_cnt     <= '0;
    end else begin
      lanes_q            <= lanes_d;
      wcnt_q             <= wcnt_d;
      wait_q             <= wait_d;
      x_q                <= x_d;
      seq_q              <= seq_d;
      uplinkUserData     <= frame_d;
      uplinkFrameValid_o <= fvalid_d;
      data_frame_cnt     <= dcnt_d;
    end
  end

endmodule

// File: tb/tb_sp3_uplink_frame_tx.sv
// Self-checking bench for sp3_uplink_frame_tx: directed scenarios plus a
// randomized phase, all compared against a queue-based frame model.
module tb_sp3_uplink_frame_tx;

  localparam int unsigned FLUSH = 4;
  localparam logic [17:0] IDLE  = 18'h2AAAA;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         frame_tick;
  logic [17:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [233:0] frame;
  logic         fvalid;
  logic [31:0]  dcnt;
  logic [17:0]  hdr;

  assign hdr = frame[233:216];

  sp3_uplink_frame_tx #(
    .FLUSH_TICKS(FLUSH),
    .IDLE_WORD  (IDLE)
  ) dut (
    .S_AXI_ACLK        (clk),
    .S_AXI_ARESETN     (rst_n),
    .en                (en),
    .frame_tick        (frame_tick),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .uplinkUserData    (frame),
    .uplinkFrameValid_o(fvalid),
    .data_frame_cnt    (dcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending words in arrival order, tick wait count, seq, counters.
  logic [17:0]  q[$];
  int unsigned  wait_m;
  logic [7:0]   seq_m;
  logic [31:0]  cnt_m;
  logic [233:0] exp_frame;
  logic         exp_valid;

  function automatic logic [233:0] model_data_frame();
    logic [233:0] f;
    logic [17:0]  x;
    logic [3:0]   c;
    f = '0;
    x = '0;
    foreach (q[k]) begin
      f[18*k +: 18] = q[k];
      x = x ^ q[k];
    end
    c = '0;
    for (int n = 0; n < 5; n++) c = c ^ 4'(x >> (4 * n));
    f[233:216] = {2'b10, seq_m, 4'(q.size()), c};
    return f;
  endfunction

  function automatic logic [233:0] model_idle_frame();
    logic [233:0] f;
    for (int k = 0; k < 12; k++) f[18*k +: 18] = IDLE;
    f[233:216] = {2'b01, seq_m, 8'h00};
    return f;
  endfunction

  task automatic model_reset();
    q.delete();
    wait_m    = 0;
    seq_m     = '0;
    cnt_m     = '0;
    exp_frame = '0;
    exp_valid = 1'b0;
  endtask

  // One clock: drive inputs, check s_ready, clock edge, update model, check outputs.
  task automatic cycle(input logic v, input logic [17:0] d, input logic t);
    logic exp_ready;
    logic acc;
    int   n;
    s_valid    = v;
    s_data     = d;
    frame_tick = t;
    #1;
    exp_ready = rst_n && en && (q.size() < 12);
    check("s_ready", 256'(s_ready), 256'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    if (t) begin
      n = q.size();
      if (n == 12 || (n > 0 && (wait_m == FLUSH - 1 || !en))) begin
        exp_frame = model_data_frame();
        exp_valid = 1'b1;
        seq_m++;
        cnt_m++;
        q.delete();
        wait_m = 0;
      end else begin
        exp_frame = model_idle_frame();
        exp_valid = 1'b0;
        if (n > 0) wait_m++;
      end
    end
    if (acc) begin
      if (q.size() == 0) wait_m = 0;
      q.push_back(d);
    end
    #1;
    check("frame", 256'(frame), 256'(exp_frame));
    check("frame_valid", 256'(fvalid), 256'(exp_valid));
    check("data_frame_cnt", 256'(dcnt), 256'(cnt_m));
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    frame_tick = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    model_reset();
    #1;
    check("rst_ready", 256'(s_ready), 256'(0));
    check("rst_frame", 256'(frame), 256'(0));
    check("rst_valid", 256'(fvalid), 256'(0));
    check("rst_cnt", 256'(dcnt), 256'(0));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Twelve words 1..12 then a tick with a 13th word already offered.
    for (int k = 1; k <= 12; k++) cycle(1'b1, 18'(k), 1'b0);
    check("full_ready", 256'(s_ready), 256'(0));
    cycle(1'b1, 18'h0000D, 1'b1);
    check("full_hdr", 256'(hdr), 256'({2'b10, 8'h00, 4'hC, 4'hC}));
    check("full_lane0", 256'(frame[17:0]), 256'(18'h00001));
    check("full_lane11", 256'(frame[215:198]), 256'(18'h0000C));
    check("full_cnt", 256'(dcnt), 256'(1));
    // Word 13 is taken once space exists and becomes lane 0 of the next frame.
    cycle(1'b1, 18'h0000D, 1'b0);
    en = 1'b0;
    cycle(1'b0, 18'h0, 1'b1);
    check("w13_hdr_count", 256'(hdr[7:4]), 256'(1));
    check("w13_lane0", 256'(frame[17:0]), 256'(18'h0000D));

    // Partial frame waits FLUSH ticks.
    en = 1'b1;
    cycle(1'b1, 18'h3FFFF, 1'b0);
    cycle(1'b1, 18'h00000, 1'b0);
    cycle(1'b1, 18'h12345, 1'b0);
    for (int t = 1; t <= 4; t++) begin
      cycle(1'b0, 18'h0, 1'b1);
      if (t < 4) begin
        check("wait_idle_valid", 256'(fvalid), 256'(0));
        check("wait_idle_lane", 256'(frame[107:90]), 256'(IDLE));
      end
      cycle(1'b0, 18'h0, 1'b0);
    end
    check("wait_flush_count", 256'(hdr[7:4]), 256'(3));
    check("wait_flush_lane3", 256'(frame[71:54]), 256'(0));

    // en drop mid-fill flushes on the next tick.
    for (int k = 0; k < 5; k++) cycle(1'b1, 18'($urandom), 1'b0);
    en = 1'b0;
    cycle(1'b1, 18'h1, 1'b0);
    check("en_drop_ready", 256'(s_ready), 256'(0));
    cycle(1'b0, 18'h0, 1'b1);
    check("en_drop_count", 256'(hdr[7:4]), 256'(5));
    en = 1'b1;

    // Asynchronous reset mid-fill discards the partial frame.
    for (int k = 0; k < 7; k++) cycle(1'b1, 18'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_frame", 256'(frame), 256'(0));
    check("async_rst_cnt", 256'(dcnt), 256'(0));
    check("async_rst_ready", 256'(s_ready), 256'(0));
    model_reset();
    #3;
    rst_n = 1'b1;
    cycle(1'b0, 18'h0, 1'b1);
    check("post_rst_hdr", 256'(hdr), 256'({2'b01, 8'h00, 8'h00}));

    // 257 full frames: seq runs 0..255 then wraps to 0.
    for (int f = 0; f <= 256; f++) begin
      for (int k = 0; k < 12; k++) cycle(1'b1, 18'($urandom), 1'b0);
      cycle(1'b0, 18'h0, 1'b1);
      check("seq_field", 256'(hdr[15:8]), 256'(f % 256));
      if (f == 255) check("cnt_256", 256'(dcnt), 256'(256));
    end

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      cycle(1'($urandom_range(0, 2) != 0), 18'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
